// File: rtl/pic_interrupt_controller_if.sv
// Signal bundle between the core (INTCON/PIE1/PIR1, decoder timing) and the
// interrupt sequencer. The core side is the master, the controller the slave.
interface pic_interrupt_controller_if;
  logic [7:0]  intcon_reg_val;
  logic [7:0]  pir1_reg_val;
  logic [7:0]  pie1_reg_val;
  logic        instr_end;
  logic        retfie_exec;
  logic        sleeping;
  logic        instr_flush;
  logic        pc_hold;
  logic        stack_push_en;
  logic        gie_clr_en;
  logic        gie_set_en;
  logic        pc_vec_en;
  logic [12:0] pc_vec_addr;
  logic        in_isr;
  logic        wake;

  modport master (
    output intcon_reg_val, pir1_reg_val, pie1_reg_val,
    output instr_end, retfie_exec, sleeping,
    input  instr_flush, pc_hold, stack_push_en, gie_clr_en,
    input  gie_set_en, pc_vec_en, pc_vec_addr, in_isr, wake
  );

  modport slave (
    input  intcon_reg_val, pir1_reg_val, pie1_reg_val,
    input  instr_end, retfie_exec, sleeping,
    output instr_flush, pc_hold, stack_push_en, gie_clr_en,
    output gie_set_en, pc_vec_en, pc_vec_addr, in_isr, wake
  );
endinterface

// File: rtl/pic_interrupt_controller.sv
// Interrupt entry/exit sequencer: forces a NOP cycle, pushes the return PC,
// clears GIE and vectors; on RETFIE re-enables GIE.
module pic_interrupt_controller #(
  parameter logic [12:0] VECTOR_ADDR = 13'h0004,
  parameter int          FORCE_CLKS  = 4
) (
  input logic clk,
  input logic rst,
  pic_interrupt_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FORCE, ISR, RETURN} state_t;

  localparam logic [2:0] LAST_CNT = 3'(FORCE_CLKS - 1);

  state_t     state, state_nxt;
  logic [2:0] force_cnt, cnt_nxt;
  logic       irq_any, irq_cond;
  logic       flush_nxt, push_nxt, vec_nxt, isr_nxt, set_nxt;
  logic       flush_q, push_q, vec_q, isr_q, set_q;

  // Enable/flag pairs line up bit for bit: [5:3] enables against [2:0] flags.
  assign irq_any  = (|(bus.intcon_reg_val[5:3] & bus.intcon_reg_val[2:0])) |
                    (bus.intcon_reg_val[6] & (|(bus.pir1_reg_val & bus.pie1_reg_val)));
  assign irq_cond = bus.intcon_reg_val[7] & irq_any;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = force_cnt;
    case (state)
      IDLE: begin
        if (bus.instr_end && irq_cond && !bus.retfie_exec) begin
          state_nxt = FORCE;
          cnt_nxt   = '0;
        end else if (bus.instr_end && bus.retfie_exec) begin
          state_nxt = RETURN;
        end
      end
      FORCE: begin
        if (force_cnt == LAST_CNT) begin
          state_nxt = ISR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = force_cnt + 3'd1;
        end
      end
      ISR:     if (bus.instr_end && bus.retfie_exec) state_nxt = RETURN;
      RETURN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave flops directly.
    flush_nxt = (state_nxt == FORCE);
    push_nxt  = flush_nxt && (cnt_nxt == 3'd0);
    vec_nxt   = flush_nxt && (cnt_nxt == LAST_CNT);
    isr_nxt   = (state_nxt == ISR);
    set_nxt   = (state_nxt == RETURN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      force_cnt <= '0;
      flush_q   <= 1'b0;
      push_q    <= 1'b0;
      vec_q     <= 1'b0;
      isr_q     <= 1'b0;
      set_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      force_cnt <= cnt_nxt;
      flush_q   <= flush_nxt;
      push_q    <= push_nxt;
      vec_q     <= vec_nxt;
      isr_q     <= isr_nxt;
      set_q     <= set_nxt;
    end
  end

  assign bus.instr_flush   = flush_q;
  assign bus.pc_hold       = flush_q;
  assign bus.stack_push_en = push_q;
  assign bus.gie_clr_en    = push_q;
  assign bus.pc_vec_en     = vec_q;
  assign bus.in_isr        = isr_q;
  assign bus.gie_set_en    = set_q;
  assign bus.pc_vec_addr   = VECTOR_ADDR;
  assign bus.wake          = bus.sleeping & irq_any;
endmodule
